wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Schedules the two register-file write ports shared by the alpha writeback, the beta writeback and the long-latency unit (mul/div result path).
- Alpha and beta writes are in-order and always win their port in the cycle they arrive.
- Long-latency results are captured into a 1-entry buffer and drained into idle port slots.
- A starvation counter forces a one-cycle writeback stall when the buffer cannot drain.

Parameters:
- STARVE_LIMIT, 4: consecutive blocked cycles before wb_stall asserts. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alpha_we  in  1  alpha write request (already link-resolved)
- alpha_dest  in  5  alpha destination register
- alpha_data  in  32  alpha write data
- beta_we  in  1  beta write request (younger than alpha)
- beta_dest  in  5  beta destination register
- beta_data  in  32  beta write data
- lu_valid  in  1  long-latency result valid
- lu_dest  in  5  long-latency destination register
- lu_data  in  32  long-latency result data
- lu_ready  out  1  buffer can accept a long-latency result
- port0_en  out  1  regfile write port 0 enable
- port0_dest  out  5  regfile write port 0 address
- port0_data  out  32  regfile write port 0 data
- port1_en  out  1  regfile write port 1 enable
- port1_dest  out  5  regfile write port 1 address
- port1_data  out  32  regfile write port 1 data
- wb_stall  out  1  freeze writeback pipeline register this cycle
- buf_valid  out  1  buffered long-latency write pending (for hazard logic)
- buf_dest  out  5  destination of the pending write

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - buf_valid=0, buf_dest=0, starve counter=0.
  - While rst=1: port enables=0, wb_stall=0, lu_ready=0.
  - After rst deasserts: lu_ready=1.
  - A pending buffered write is discarded on reset.
- Write filtering:
  - Any request with dest==0 is treated as no request (enable forced 0).
  - If alpha_we and beta_we target the same dest, alpha is suppressed; beta (younger) wins.
- Pipe mapping (combinational, 0 latency): alpha drives port0; beta drives port1.
- Handshake and latency:
  - lu_ready = !buf_valid (registered state).
  - Capture occurs at the clock edge when lu_valid && lu_ready; the producer holds lu_* until accepted.
  - Earliest regfile write is the cycle after capture; the buffer never bypasses same-cycle.
- Drain, when buf_valid:
  - Use port1 if beta's slot is empty, else port0 if alpha's slot is empty; port1 is preferred.
  - A drained entry clears buf_valid at the next edge.
  - A new capture is possible the cycle after drain, not the same edge.
- WAW kill: if buf_valid and an enabled alpha or beta write has dest==buf_dest, the buffered entry is stale. It is dropped (buf_valid cleared at the edge) and is not written.
- Starvation:
  - Counter increments each cycle buf_valid && both port slots taken by pipes.
  - It resets to 0 whenever the buffer drains, is killed, or is empty.
  - It saturates at STARVE_LIMIT.
  - wb_stall = buf_valid && counter==STARVE_LIMIT (from registered state).
  - While wb_stall=1, alpha and beta are gated off both ports and the buffer drains to port1. Upstream holds its writeback register, so the same alpha/beta values reappear next cycle.
  - The WAW kill check is also disabled in a stall cycle, because gated writes do not happen.
- Counter width: 4 bits.

Decomposition:
- Shared package: wb_req_t struct {we, dest[4:0], data[31:0]}, REG_ZERO constant, STARVE_CNT_W=4.
- Optional sub-module wb_lu_buffer: the 1-entry buffer with ready/valid handshake, kill input and drain input.
- Arbitration and starvation logic stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with lu_valid=1 -> lu_ready=0, no port enables. Cycle after release -> lu_ready=1, buf_valid=0.
- Idle drain: alpha_we=1 dest=3; beta idle; lu_valid dest=7 data=0xDEAD accepted at cycle N -> cycle N+1: port1_en=1 dest=7 data=0xDEAD, port0 dest=3. Cycle N+2: lu_ready=1.
- Same-dest pipes: alpha and beta both write dest=5 (0x1, 0x2) -> port0_en=0, port1 writes 0x2.
- WAW kill: buffer holds dest=9; beta writes dest=9 0x55 while alpha is busy -> buffered value is never written; buf_valid=0 next cycle.
- Starvation with STARVE_LIMIT=4: buffer holds dest=10 and both pipes write other regs every cycle -> wb_stall=1 on the 5th blocked cycle. In that cycle: port0_en=0, port1 writes dest=10. Next cycle wb_stall=0 and the pipe writes resume.
- dest=0: lu_dest=0 accepted -> buffer entry produces no port enable and drains without a write; alpha_dest=0 -> port0_en=0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the writeback port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_W        = 5;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_CNT_W = 4;

  localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

  // One register-file write request / buffered entry (we doubles as valid).
  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // A request only counts if it is enabled and does not target the zero register.
  function automatic logic req_live(input wb_req_t r);
    return r.we && (r.dest != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_lu_buffer.sv
// One-entry holding buffer for long-latency results.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_req_i         producer request (we = valid), held until accepted
//   in_ready_o       buffer empty and out of reset
//   drain_i, kill_i  retire the held entry at the next edge (written / stale)
//   buf_o            held entry (we = valid)
module wb_lu_buffer
  import wb_port_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  wb_req_t in_req_i,
  output logic    in_ready_o,
  input  logic    drain_i,
  input  logic    kill_i,
  output wb_req_t buf_o
);

  wb_req_t entry_q, entry_d;
  logic    capture;

  // Ready only depends on registered state, so a drain frees the slot one cycle later.
  always_comb begin : next_entry
    entry_d    = entry_q;
    in_ready_o = !rst && !entry_q.we;
    capture    = in_req_i.we && in_ready_o;
    if (drain_i || kill_i) begin
      entry_d.we = 1'b0;
    end else if (capture) begin
      entry_d.we   = 1'b1;
      entry_d.dest = in_req_i.dest;
      entry_d.data = in_req_i.data;
    end
  end

  always_ff @(posedge clk) begin : entry_reg
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign buf_o = entry_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Schedules the two register-file write ports between the alpha pipe, the
// beta pipe and the buffered long-latency result.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alpha_we/dest/data            alpha writeback request (owns port 0)
//   beta_we/dest/data             beta writeback request (owns port 1, younger)
//   lu_valid/dest/data, lu_ready  long-latency result handshake
//   port{0,1}_en/dest/data        register-file write ports
//   wb_stall                      freeze writeback so the buffer can drain
//   buf_valid, buf_dest           pending buffered write, for hazard logic
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alpha_we,
  input  logic [REG_W-1:0]  alpha_dest,
  input  logic [DATA_W-1:0] alpha_data,
  input  logic              beta_we,
  input  logic [REG_W-1:0]  beta_dest,
  input  logic [DATA_W-1:0] beta_data,
  input  logic              lu_valid,
  input  logic [REG_W-1:0]  lu_dest,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic              port0_en,
  output logic [REG_W-1:0]  port0_dest,
  output logic [DATA_W-1:0] port0_data,
  output logic              port1_en,
  output logic [REG_W-1:0]  port1_dest,
  output logic [DATA_W-1:0] port1_data,
  output logic              wb_stall,
  output logic              buf_valid,
  output logic [REG_W-1:0]  buf_dest
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  wb_req_t alpha_req, beta_req, lu_req, buf_q;
  logic    alpha_live, beta_live;
  logic    drain, kill, blocked, stall;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;

  wb_lu_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .in_req_i   (lu_req),
    .in_ready_o (lu_ready),
    .drain_i    (drain),
    .kill_i     (kill),
    .buf_o      (buf_q)
  );

  // Pack requests; alpha loses to beta on a same-destination collision.
  always_comb begin : filter
    alpha_req  = '{we: alpha_we, dest: alpha_dest, data: alpha_data};
    beta_req   = '{we: beta_we,  dest: beta_dest,  data: beta_data};
    lu_req     = '{we: lu_valid, dest: lu_dest,    data: lu_data};
    beta_live  = req_live(beta_req);
    alpha_live = req_live(alpha_req) && !(beta_live && (beta_req.dest == alpha_req.dest));
  end

  // Port assignment, buffer drain/kill, and starvation detection.
  always_comb begin : arbitrate
    port0_en   = 1'b0;
    port0_dest = alpha_req.dest;
    port0_data = alpha_req.data;
    port1_en   = 1'b0;
    port1_dest = beta_req.dest;
    port1_data = beta_req.data;
    drain      = 1'b0;
    kill       = 1'b0;
    blocked    = 1'b0;
    stall      = 1'b0;

    if (!rst) begin
      stall = buf_q.we && (starve_q == LIMIT);
      if (stall) begin
        // Pipes are gated this cycle, so no WAW check: the buffer takes port 1.
        port1_en   = buf_q.dest != REG_ZERO;
        port1_dest = buf_q.dest;
        port1_data = buf_q.data;
        drain      = 1'b1;
      end else begin
        port0_en = alpha_live;
        port1_en = beta_live;
        if (buf_q.we) begin
          if ((alpha_live && (alpha_req.dest == buf_q.dest)) ||
              (beta_live  && (beta_req.dest  == buf_q.dest))) begin
            kill = 1'b1;
          end else if (buf_q.dest == REG_ZERO) begin
            // Write to the zero register: retire without using a port.
            drain = 1'b1;
          end else if (!beta_live) begin
            port1_en   = 1'b1;
            port1_dest = buf_q.dest;
            port1_data = buf_q.data;
            drain      = 1'b1;
          end else if (!alpha_live) begin
            port0_en   = 1'b1;
            port0_dest = buf_q.dest;
            port0_data = buf_q.data;
            drain      = 1'b1;
          end else begin
            blocked = 1'b1;
          end
        end
      end
    end

    wb_stall = stall;
  end

  // Count consecutive blocked cycles; any other outcome restarts the count.
  always_comb begin : starve_next
    starve_d = '0;
    if (blocked) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin : starve_reg
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign buf_valid = buf_q.we;
  assign buf_dest  = buf_q.dest;

endmodule
